// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed wait latency.
// Optional per-byte write enables via `define DMEM_RESPONDER_BYTE_EN_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_RESPONDER_BYTE_EN_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state;
    state_t next_state;

    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [3:0]  op_be;
    logic        op_err;
    logic [AW-1:0] op_idx;

    // With LATENCY=0 the commit happens on the accept edge, so the live inputs
    // stand in for the latched copy while still in IDLE.
    always_comb begin
        if (state == IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
`ifdef DMEM_RESPONDER_BYTE_EN_EN
            op_be    = req_be;
`else
            op_be    = 4'hF;
`endif
        end else begin
            op_we    = lat_we;
            op_addr  = lat_addr;
            op_wdata = lat_wdata;
            op_be    = lat_be;
        end
        op_err = (op_addr[1:0] != 2'b00) || ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
        op_idx = op_addr[AW+1:2];
    end

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    assign enter_resp = !reset && (state != RESP) && (next_state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= op_we;
                lat_addr  <= op_addr;
                lat_wdata <= op_wdata;
                lat_be    <= op_be;
                cnt       <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_we || op_err) ? '0 : mem[op_idx];
            end
        end
    end

    // Memory has no reset; contents survive reset and errored writes are dropped.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (op_be[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0,
// both compared against an array model of the word memory and the handshake timing.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
`ifdef DMEM_RESPONDER_BYTE_EN_EN
    logic [3:0]  req_be    [2];
`endif
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    logic [31:0] model [2][64];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        .req_be(req_be[0]),
`endif
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut_lat0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        .req_be(req_be[1]),
`endif
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction; called at #1 after a rising edge with the instance idle.
    task automatic do_op(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] mask;
        int n;
        exp_err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
        exp_rdata = (we || exp_err) ? 32'h0 : model[d][addr[7:2]];

        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        req_be[d]    = be;
`endif
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        @(posedge clk); #1;
        // Scramble inputs after accept; the latched request must not change.
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom ^ {28'h0, be};
`ifdef DMEM_RESPONDER_BYTE_EN_EN
        req_be[d]    = 4'($urandom);
`endif
        n = 0;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            check("wait_req_ready", 32'(req_ready[d]), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("latency_cycles", 32'(n + 1), 32'(lat_of(d) + 1));
        check("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
        check("rsp_rdata", rsp_rdata[d], exp_rdata);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_rdata", rsp_rdata[d], exp_rdata);
            check("hold_err", 32'(rsp_err[d]), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check("after_req_ready", 32'(req_ready[d]), 32'd1);
        check("after_rsp_valid", 32'(rsp_valid[d]), 32'd0);

        if (we && !exp_err) begin
`ifdef DMEM_RESPONDER_BYTE_EN_EN
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
`else
            mask = 32'hFFFF_FFFF;
`endif
            model[d][addr[7:2]] = (model[d][addr[7:2]] & ~mask) | (wdata & mask);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  be;
        int d;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b0;
`ifdef DMEM_RESPONDER_BYTE_EN_EN
            req_be[i]    = 4'hF;
`endif
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata[i], 32'd0);
            check("reset_req_ready", 32'(req_ready[i]), 32'd1);
        end
        reset = 1'b0;

        // Give every word a known value.
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 64; w++) begin
                do_op(i, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
            end
        end

        do_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_op(0, 1'b0, 32'h10, 32'h0, 4'hF, 4);
        do_op(0, 1'b0, 32'h13, 32'h0, 4'hF, 1);
        do_op(0, 1'b0, 32'h100, 32'h0, 4'hF, 0);
        do_op(0, 1'b1, 32'h13, 32'hCAFEF00D, 4'hF, 0);
        do_op(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);

        // Reset while waiting: write to 0x20 must be abandoned.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("wait_state_ready", 32'(req_ready[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_wait_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_wait_ready", 32'(req_ready[0]), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_wait_quiet", 32'(rsp_valid[0]), 32'd0);
        end
        do_op(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);

        // Reset has priority over a simultaneous request.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid[0] = 1'b0;
        check("rst_prio_ready", 32'(req_ready[0]), 32'd1);
        check("rst_prio_valid", 32'(rsp_valid[0]), 32'd0);

        // Reset during RESP drops the response, even with rsp_ready high.
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h4;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("lat0_resp_valid", 32'(rsp_valid[1]), 32'd1);
        check("lat0_resp_data", rsp_rdata[1], model[1][1]);
        reset = 1'b1; rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; rsp_ready[1] = 1'b0;
        check("rst_resp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rst_resp_rdata", rsp_rdata[1], 32'd0);
        check("rst_resp_ready", 32'(req_ready[1]), 32'd1);

        do_op(1, 1'b0, 32'h40, 32'h0, 4'hF, 0);
        do_op(1, 1'b1, 32'hFC, 32'h0BADF00D, 4'hF, 0);
        do_op(1, 1'b0, 32'hFC, 32'h0, 4'hF, 0);

`ifdef DMEM_RESPONDER_BYTE_EN_EN
        do_op(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 0);
        do_op(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 0);
        do_op(0, 1'b0, 32'h8, 32'h0, 4'hF, 0);
        check("byte_en_word", model[0][2], 32'h11BB33DD);
        do_op(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 0);
        do_op(0, 1'b0, 32'h8, 32'h0, 4'hF, 0);
`endif

        for (int k = 0; k < 150; k++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
            end else begin
                a = 32'($urandom_range(0, 66) * 4);
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            end
`ifdef DMEM_RESPONDER_BYTE_EN_EN
            be = 4'($urandom);
`else
            be = 4'hF;
`endif
            do_op(d, 1'($urandom), a, $urandom, be, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
